tx_ctrl_pack_fifo: RTL and testbench

//  Single-clock, width-converting FIFO for the TX control path. Packs RATIO

---
 rtl/tx_ctrl_pack_fifo.sv | 169 ++++++++++++++++
 tb/tb_tx_ctrl_pack_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ctrl_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tx_ctrl_pack_fifo
// Description : Single-clock width-converting FIFO for the TX control path.
//               RATIO narrow write words are packed (first word in the LSBs)
//               into one wide word, which is stored in an inferred
//               simple-dual-port RAM. Wide words pop with block-RAM latency:
//               one cycle, or two with OUTPUT_REG=1.
// Ports       : clk, rst (async, active high), flush (sync clear)
//               wr_data/wr_en           narrow write side
//               wr_full/wr_almost_full  level flags (level in wide words)
//               wr_partial              packer holds 1..RATIO-1 lanes
//               rd_en/rd_data/rd_valid  pop request, popped word, strobe
//               rd_empty/rd_level       committed wide-word occupancy
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module tx_ctrl_pack_fifo #(
    parameter int WR_DATA_WIDTH  = 8,
    parameter int RATIO          = 2,
    parameter int RD_ADDR_WIDTH  = 7,
    parameter int ALMOST_FULL_TH = 120,
    parameter int OUTPUT_REG     = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [WR_DATA_WIDTH-1:0]         wr_data,
    input  logic                             wr_en,
    output logic                             wr_full,
    output logic                             wr_almost_full,
    output logic                             wr_partial,
    input  logic                             rd_en,
    output logic [WR_DATA_WIDTH*RATIO-1:0]   rd_data,
    output logic                             rd_valid,
    output logic                             rd_empty,
    output logic [RD_ADDR_WIDTH:0]           rd_level
);

    localparam int                   c_rd_width   = WR_DATA_WIDTH * RATIO;
    localparam int                   c_depth      = 1 << RD_ADDR_WIDTH;
    localparam logic [RD_ADDR_WIDTH:0] c_full_lvl  = (RD_ADDR_WIDTH+1)'(c_depth);
    localparam logic [RD_ADDR_WIDTH:0] c_afull_lvl = (RD_ADDR_WIDTH+1)'(ALMOST_FULL_TH);

    logic [RD_ADDR_WIDTH-1:0] r_wr_ptr;
    logic [RD_ADDR_WIDTH-1:0] r_rd_ptr;
    logic [RD_ADDR_WIDTH:0]   r_level;
    logic                     w_wr_accept;
    logic                     w_commit;
    logic                     w_pop;
    logic [c_rd_width-1:0]    w_wide_word;
    logic [c_rd_width-1:0]    r_mem [c_depth];

    // All occupancy flags come from the registered level only.
    assign rd_level       = r_level;
    assign rd_empty       = (r_level == '0);
    assign wr_full        = (r_level == c_full_lvl);
    assign wr_almost_full = (r_level >= c_afull_lvl);

    assign w_wr_accept = wr_en & ~wr_full  & ~flush;
    assign w_pop       = rd_en & ~rd_empty & ~flush;

    // ------------------------------------------------------------------
    // Lane packer
    // ------------------------------------------------------------------
    generate
        if (RATIO > 1) begin : g_pack
            localparam int c_lane_w = $clog2(RATIO);
            logic [c_lane_w-1:0]                    r_lane;
            logic [(RATIO-1)*WR_DATA_WIDTH-1:0]     r_pack;

            // The last lane never needs storing: it is taken straight from
            // wr_data in the commit cycle.
            assign w_commit    = w_wr_accept & (r_lane == c_lane_w'(RATIO-1));
            assign w_wide_word = {wr_data, r_pack};
            assign wr_partial  = (r_lane != '0);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_lane <= '0;
                end else if (flush) begin
                    r_lane <= '0;
                end else if (w_wr_accept) begin
                    r_lane <= w_commit ? '0 : r_lane + c_lane_w'(1);
                end
            end

            // Partial lane data is don't-care after reset/flush, so no reset.
            always_ff @(posedge clk) begin
                if (w_wr_accept && !w_commit) begin
                    r_pack[r_lane*WR_DATA_WIDTH +: WR_DATA_WIDTH] <= wr_data;
                end
            end
        end else begin : g_no_pack
            assign w_commit    = w_wr_accept;
            assign w_wide_word = wr_data;
            assign wr_partial  = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pointers and level
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_commit) r_wr_ptr <= r_wr_ptr + RD_ADDR_WIDTH'(1);
            if (w_pop)    r_rd_ptr <= r_rd_ptr + RD_ADDR_WIDTH'(1);
            case ({w_commit, w_pop})
                2'b10:   r_level <= r_level + (RD_ADDR_WIDTH+1)'(1);
                2'b01:   r_level <= r_level - (RD_ADDR_WIDTH+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Read and write addresses only coincide when the FIFO is empty (no pop)
    // or full (no commit), so no read-during-write bypass is required.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_wr_ptr] <= w_wide_word;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------
    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic [c_rd_width-1:0] r_ram_q;
            logic                  r_ram_vld;

            always_ff @(posedge clk) begin
                if (w_pop) r_ram_q <= r_mem[r_rd_ptr];
            end

            // A flush kills a word still in flight in the RAM stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ram_vld <= 1'b0;
                    rd_valid  <= 1'b0;
                    rd_data   <= '0;
                end else begin
                    r_ram_vld <= w_pop;
                    rd_valid  <= r_ram_vld & ~flush;
                    if (r_ram_vld && !flush) rd_data <= r_ram_q;
                end
            end
        end else begin : g_no_out_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= w_pop;
                    if (w_pop) rd_data <= r_mem[r_rd_ptr];
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tx_ctrl_pack_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tx_ctrl_pack_fifo
// Description : Self-checking bench for tx_ctrl_pack_fifo. Two instances:
//               A (W=8, RATIO=2, depth 128, AF 120, OUTPUT_REG=0) and
//               B (W=8, RATIO=4, depth 16, AF 12, OUTPUT_REG=1). One is
//               active at a time; the other sees idle inputs. A queue-based
//               reference model predicts every output after each clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_ctrl_pack_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       sel = 1'b0;

    logic        a_full, a_afull, a_part, a_valid, a_empty;
    logic [15:0] a_data;
    logic [7:0]  a_level;
    logic        b_full, b_afull, b_part, b_valid, b_empty;
    logic [31:0] b_data;
    logic [4:0]  b_level;

    always #5 clk = ~clk;

    tx_ctrl_pack_fifo #(
        .WR_DATA_WIDTH(8), .RATIO(2), .RD_ADDR_WIDTH(7),
        .ALMOST_FULL_TH(120), .OUTPUT_REG(0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush & ~sel),
        .wr_data(wr_data), .wr_en(wr_en & ~sel),
        .wr_full(a_full), .wr_almost_full(a_afull), .wr_partial(a_part),
        .rd_en(rd_en & ~sel), .rd_data(a_data), .rd_valid(a_valid),
        .rd_empty(a_empty), .rd_level(a_level)
    );

    tx_ctrl_pack_fifo #(
        .WR_DATA_WIDTH(8), .RATIO(4), .RD_ADDR_WIDTH(4),
        .ALMOST_FULL_TH(12), .OUTPUT_REG(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush & sel),
        .wr_data(wr_data), .wr_en(wr_en & sel),
        .wr_full(b_full), .wr_almost_full(b_afull), .wr_partial(b_part),
        .rd_en(rd_en & sel), .rd_data(b_data), .rd_valid(b_valid),
        .rd_empty(b_empty), .rd_level(b_level)
    );

    logic [31:0] o_data, o_level;
    logic        o_valid, o_empty, o_full, o_afull, o_part;
    assign o_data  = sel ? b_data : {16'h0, a_data};
    assign o_level = sel ? {27'h0, b_level} : {24'h0, a_level};
    assign o_valid = sel ? b_valid : a_valid;
    assign o_empty = sel ? b_empty : a_empty;
    assign o_full  = sel ? b_full  : a_full;
    assign o_afull = sel ? b_afull : a_afull;
    assign o_part  = sel ? b_part  : a_part;

    // Reference model state
    int          m_ratio, m_lat, m_depth, m_af, m_pops;
    logic [31:0] mq[$];
    logic [7:0]  ml[$];
    logic        m_v1, m_valid;
    logic [31:0] m_d1, m_data;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string ph);
        check_val({ph, ".valid"},   32'(o_valid), 32'(m_valid));
        check_val({ph, ".data"},    o_data, m_data);
        check_val({ph, ".level"},   o_level, 32'(mq.size()));
        check_val({ph, ".empty"},   32'(o_empty), 32'(mq.size() == 0));
        check_val({ph, ".full"},    32'(o_full), 32'(mq.size() == m_depth));
        check_val({ph, ".afull"},   32'(o_afull), 32'(mq.size() >= m_af));
        check_val({ph, ".partial"}, 32'(o_part), 32'(ml.size() != 0));
    endtask

    task automatic model_clear();
        mq.delete();
        ml.delete();
        m_v1    = 1'b0;
        m_valid = 1'b0;
        m_d1    = '0;
        m_data  = '0;
    endtask

    task automatic select_dut(input logic s);
        sel = s;
        if (s) begin
            m_ratio = 4; m_lat = 2; m_depth = 16;  m_af = 12;
        end else begin
            m_ratio = 2; m_lat = 1; m_depth = 128; m_af = 120;
        end
        m_pops = 0;
    endtask

    task automatic drive(input logic w, input logic r, input logic f, input logic [7:0] d);
        wr_en = w; rd_en = r; flush = f; wr_data = d;
    endtask

    // Applied #1 after a rising edge; leaves the bench #1 after a rising edge.
    task automatic do_reset(input string ph);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        #1;
        model_clear();
        check_outputs(ph);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: model consumes the current inputs against its pre-edge
    // state, then every output is compared just after the edge.
    task automatic step(input string tag);
        int          lvl;
        bit          p, acc;
        logic [31:0] popped, w;
        lvl    = mq.size();
        popped = '0;
        @(posedge clk);
        if (flush) begin
            mq.delete();
            ml.delete();
            m_v1    = 1'b0;
            m_valid = 1'b0;
        end else begin
            p   = rd_en && (lvl != 0);
            acc = wr_en && (lvl != m_depth);
            if (m_lat == 2) begin
                m_valid = m_v1;
                if (m_v1) m_data = m_d1;
            end
            if (p) begin
                popped = mq.pop_front();
                m_pops++;
            end
            if (m_lat == 1) begin
                m_valid = p;
                if (p) m_data = popped;
            end else begin
                m_v1 = p;
                if (p) m_d1 = popped;
            end
            if (acc) begin
                ml.push_back(wr_data);
                if (ml.size() == m_ratio) begin
                    w = '0;
                    foreach (ml[k]) w = w | (32'(ml[k]) << (8 * k));
                    mq.push_back(w);
                    ml.delete();
                end
            end
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        select_dut(1'b0);
        model_clear();
        @(posedge clk);
        #1;
        do_reset("a_rst");

        // 1: basic packing order and 1-cycle latency
        drive(1'b1, 1'b0, 1'b0, 8'h11); step("t1");
        drive(1'b1, 1'b0, 1'b0, 8'h22); step("t1");
        drive(1'b1, 1'b0, 1'b0, 8'h33); step("t1");
        drive(1'b1, 1'b0, 1'b0, 8'h44); step("t1");
        drive(1'b0, 1'b1, 1'b0, 8'h00); step("t1");
        check_val("t1_word0", o_data, 32'h2211);
        step("t1");
        check_val("t1_word1", o_data, 32'h4433);
        drive(1'b0, 1'b0, 1'b0, 8'h00); step("t1");

        // 2: fill to full, drop the extra write, drain in order
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'($urandom)); step("t2w");
            if (i == 237) check_val("t2_afull_below", 32'(o_afull), 32'd0);
            if (i == 239) check_val("t2_afull_at", 32'(o_afull), 32'd1);
        end
        check_val("t2_full", 32'(o_full), 32'd1);
        check_val("t2_level", o_level, 32'd128);
        for (int i = 0; i < 129; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00); step("t2r");
        end
        check_val("t2_empty", 32'(o_empty), 32'd1);

        // 3: commit and pop together at DEPTH-1
        for (int i = 0; i < 255; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'($urandom)); step("t3w");
        end
        drive(1'b1, 1'b1, 1'b0, 8'h5A); step("t3cp");
        check_val("t3_level", o_level, 32'd127);
        check_val("t3_notfull", 32'(o_full), 32'd0);
        for (int i = 0; i < 128; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00); step("t3r");
        end

        // 4: flush discards a partial word
        drive(1'b1, 1'b0, 1'b0, 8'hAA); step("t4");
        check_val("t4_partial", 32'(o_part), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 8'h00); step("t4f");
        drive(1'b1, 1'b0, 1'b0, 8'h01); step("t4");
        drive(1'b1, 1'b0, 1'b0, 8'h02); step("t4");
        drive(1'b0, 1'b1, 1'b0, 8'h00); step("t4");
        check_val("t4_data", o_data, 32'h0201);

        // 5: async reset mid-burst, first pop afterwards ignored
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, ($urandom % 2) == 1, 1'b0, 8'($urandom)); step("t5b");
        end
        do_reset("t5_rst");
        drive(1'b0, 1'b1, 1'b0, 8'h00); step("t5p");
        check_val("t5_novalid", 32'(o_valid), 32'd0);
        check_val("t5_empty", 32'(o_empty), 32'd1);

        // Random traffic on A, including flushes
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 2) == 1, ($urandom % 64) == 0, 8'($urandom));
            step("a_rand");
        end

        // 6: instance B, back-to-back across pointer wrap, 2-cycle latency
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        select_dut(1'b1);
        do_reset("b_rst");
        for (int i = 0; i < 2600; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'($urandom)); step("t6");
        end
        check_val("t6_transfers", 32'(m_pops >= 600), 32'd1);
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom % 3) != 0, ($urandom % 4) == 0, ($urandom % 80) == 0, 8'($urandom));
            step("b_rand");
        end
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00); step("b_drain");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
